// File: rtl/lc3_mem_arbiter_if.sv
// Core/memory bus bundle for lc3_mem_arbiter.
// The arbiter uses the master modport. The core and memory environment use the slave modport.
interface lc3_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              instrmem_rd;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] Instr_dout;
  logic              complete_instr;
  logic              data_req;
  logic              Data_rd;
  logic [ADDR_W-1:0] Data_addr;
  logic [DATA_W-1:0] Data_din;
  logic [DATA_W-1:0] Data_dout;
  logic              complete_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  instrmem_rd, pc, data_req, Data_rd, Data_addr, Data_din, mem_rdata, mem_ack,
    output Instr_dout, complete_instr, Data_dout, complete_data,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output instrmem_rd, pc, data_req, Data_rd, Data_addr, Data_din, mem_rdata, mem_ack,
    input  Instr_dout, complete_instr, Data_dout, complete_data,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Shares one single-port memory between the LC3 fetch path and the LC3 data path.
// Define LC3_ARB_TIMEOUT_EN to enable the per-access wait timeout and the sticky timeout_err flag.
module lc3_mem_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  lc3_mem_arbiter_if.master    bus,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {IDLE, BUS_I, BUS_D, DONE_I, DONE_D} state_t;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("lc3_mem_arbiter: TIMEOUT_CYC must be >= 2");
  end

  state_t            state_q, state_d;
  logic              last_d;
  logic              grant_d, grant_i;
  logic              in_bus;
  logic              tmo;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] data_q;

  assign in_bus = (state_q == BUS_I) || (state_q == BUS_D);

`ifdef LC3_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] wait_q;

  // A mem_ack on the expiring edge takes priority, so the access completes normally.
  assign tmo = in_bus && !bus.mem_ack && (wait_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_q      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant_d || grant_i)
        wait_q <= '0;
      else if (in_bus && !bus.mem_ack)
        wait_q <= wait_q + CNT_W'(1);
      if (tmo)
        timeout_err <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state_q)
      IDLE: begin
        // Data has priority, except directly after a data grant when a fetch is waiting.
        if (bus.data_req && (!bus.instrmem_rd || !last_d)) begin
          state_d = BUS_D;
          grant_d = 1'b1;
        end else if (bus.instrmem_rd) begin
          state_d = BUS_I;
          grant_i = 1'b1;
        end
      end
      BUS_I:   if (bus.mem_ack || tmo) state_d = DONE_I;
      BUS_D:   if (bus.mem_ack || tmo) state_d = DONE_D;
      DONE_I:  state_d = IDLE;
      DONE_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_d  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      instr_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        last_d  <= 1'b1;
        addr_q  <= bus.Data_addr;
        wdata_q <= bus.Data_din;
        we_q    <= !bus.Data_rd;
      end else if (grant_i) begin
        last_d  <= 1'b0;
        addr_q  <= bus.pc;
        we_q    <= 1'b0;
      end
      if (state_q == BUS_I) begin
        if (bus.mem_ack)  instr_q <= bus.mem_rdata;
        else if (tmo)     instr_q <= '0;
      end
      if (state_q == BUS_D && !we_q) begin
        if (bus.mem_ack)  data_q <= bus.mem_rdata;
        else if (tmo)     data_q <= '0;
      end
    end
  end

  assign bus.mem_req        = in_bus;
  assign bus.mem_we         = in_bus && we_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.Instr_dout     = instr_q;
  assign bus.Data_dout      = data_q;
  assign bus.complete_instr = (state_q == DONE_I);
  assign bus.complete_data  = (state_q == DONE_D);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed-vector bench for lc3_mem_arbiter; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lc3_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic timeout_err;
  int   n_vec  = 0;
  int   n_miss = 0;

  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instrmem_rd = 1'b0;
    bus.pc          = '0;
    bus.data_req    = 1'b0;
    bus.Data_rd     = 1'b1;
    bus.Data_addr   = '0;
    bus.Data_din    = '0;
    bus.mem_rdata   = '0;
    bus.mem_ack     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Reset state
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_cmp_i",   32'(bus.complete_instr), 32'd0);
    check("rst_cmp_d",   32'(bus.complete_data), 32'd0);
    check("rst_idout",   32'(bus.Instr_dout), 32'h0);
    check("rst_ddout",   32'(bus.Data_dout), 32'h0);
    check("rst_tmo",     32'(timeout_err), 32'd0);

    // Zero-wait fetch
    bus.instrmem_rd = 1'b1; bus.pc = 16'h3000;
    tick();
    check("f0_req_c1",  32'(bus.mem_req), 32'd1);
    check("f0_we_c1",   32'(bus.mem_we), 32'd0);
    check("f0_addr_c1", 32'(bus.mem_addr), 32'h3000);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1261;
    tick();
    check("f0_cmp_c2",  32'(bus.complete_instr), 32'd1);
    check("f0_dout_c2", 32'(bus.Instr_dout), 32'h1261);
    check("f0_req_c2",  32'(bus.mem_req), 32'd0);
    bus.instrmem_rd = 1'b0; bus.mem_ack = 1'b0;
    tick();
    check("f0_cmp_c3",  32'(bus.complete_instr), 32'd0);
    check("f0_req_c3",  32'(bus.mem_req), 32'd0);

    // Write with 3 wait cycles; core-side address change mid-access must not leak through
    bus.data_req = 1'b1; bus.Data_rd = 1'b0; bus.Data_addr = 16'h4000; bus.Data_din = 16'hBEEF;
    for (int c = 1; c <= 4; c++) begin
      bus.mem_ack = 1'b0;
      tick();
      if (c == 2) begin bus.Data_addr = 16'h5555; bus.Data_din = 16'h0000; bus.Data_rd = 1'b1; end
      check($sformatf("wr_we_c%0d", c),    32'(bus.mem_we), 32'd1);
      check($sformatf("wr_addr_c%0d", c),  32'(bus.mem_addr), 32'h4000);
      check($sformatf("wr_wdata_c%0d", c), 32'(bus.mem_wdata), 32'hBEEF);
      check($sformatf("wr_cmp_c%0d", c),   32'(bus.complete_data), 32'd0);
      if (c == 4) begin bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD; end
    end
    tick();
    check("wr_cmp_c5",  32'(bus.complete_data), 32'd1);
    check("wr_we_c5",   32'(bus.mem_we), 32'd0);
    check("wr_dout_c5", 32'(bus.Data_dout), 32'h0);
    bus.data_req = 1'b0; bus.mem_ack = 1'b0;
    tick();
    check("wr_cmp_c6",  32'(bus.complete_data), 32'd0);

    // Both requests held from reset, memory always acknowledging: grants D, I, D, I
    idle_inputs();
    reset = 1'b0;
    bus.instrmem_rd = 1'b1; bus.pc = 16'h3000;
    bus.data_req = 1'b1; bus.Data_rd = 1'b1; bus.Data_addr = 16'h4000;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("arb_req_k%0d", k), 32'(bus.mem_req), 32'(k % 3 == 1));
      check($sformatf("arb_cd_k%0d", k),  32'(bus.complete_data), 32'(k == 2 || k == 8));
      check($sformatf("arb_ci_k%0d", k),  32'(bus.complete_instr), 32'(k == 5 || k == 11));
      if (k % 3 == 1)
        check($sformatf("arb_addr_k%0d", k), 32'(bus.mem_addr),
              (k == 1 || k == 7) ? 32'h4000 : 32'h3000);
      if (k == 2) check("arb_ddout", 32'(bus.Data_dout), 32'h7777);
      if (k == 2) check("arb_idout_pre", 32'(bus.Instr_dout), 32'h0);
      if (k == 5) check("arb_idout", 32'(bus.Instr_dout), 32'h7777);
    end

    // Reset during the second wait cycle of a data read
    idle_inputs();
    do_reset();
    bus.data_req = 1'b1; bus.Data_rd = 1'b1; bus.Data_addr = 16'h4100;
    tick();
    check("rr_req_c1", 32'(bus.mem_req), 32'd1);
    tick();
    check("rr_req_c2", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rr_req_async", 32'(bus.mem_req), 32'd0);
    check("rr_cd_async",  32'(bus.complete_data), 32'd0);
    bus.data_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1111;
    tick();
    reset = 1'b1;
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rr_cd_after%0d", c), 32'(bus.complete_data), 32'd0);
      check($sformatf("rr_req_after%0d", c), 32'(bus.mem_req), 32'd0);
    end
    check("rr_ddout", 32'(bus.Data_dout), 32'h0);
    bus.instrmem_rd = 1'b1; bus.pc = 16'h3010;
    tick();
    check("rr_f_addr", 32'(bus.mem_addr), 32'h3010);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5A5A;
    tick();
    check("rr_f_cmp",  32'(bus.complete_instr), 32'd1);
    check("rr_f_dout", 32'(bus.Instr_dout), 32'h5A5A);
    bus.instrmem_rd = 1'b0; bus.mem_ack = 1'b0;
    tick();

    // Fetch request dropped in its BUS_I cycle still completes
    bus.instrmem_rd = 1'b1; bus.pc = 16'h3020;
    tick();
    check("dr_req_c1", 32'(bus.mem_req), 32'd1);
    bus.instrmem_rd = 1'b0;
    tick();
    check("dr_req_c2", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0E05;
    tick();
    check("dr_cmp_c3",  32'(bus.complete_instr), 32'd1);
    check("dr_dout_c3", 32'(bus.Instr_dout), 32'h0E05);
    bus.mem_ack = 1'b0;
    tick();
    check("dr_cmp_c4", 32'(bus.complete_instr), 32'd0);
    check("dr_req_c4", 32'(bus.mem_req), 32'd0);
    check("dr_tmo",    32'(timeout_err), 32'd0);

`ifdef LC3_ARB_TIMEOUT_EN
    // Fetch that is never acknowledged is forced to finish after 8 BUS cycles
    bus.instrmem_rd = 1'b1; bus.pc = 16'h3030;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("to_req_c%0d", c), 32'(bus.mem_req), 32'd1);
      check($sformatf("to_ci_c%0d", c),  32'(bus.complete_instr), 32'd0);
    end
    tick();
    check("to_cmp",  32'(bus.complete_instr), 32'd1);
    check("to_dout", 32'(bus.Instr_dout), 32'h0);
    check("to_err",  32'(timeout_err), 32'd1);
    bus.instrmem_rd = 1'b0;
    tick();
    bus.instrmem_rd = 1'b1; bus.pc = 16'h3040;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h2222;
    tick();
    check("to_ok_cmp",  32'(bus.complete_instr), 32'd1);
    check("to_ok_dout", 32'(bus.Instr_dout), 32'h2222);
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    bus.instrmem_rd = 1'b0; bus.mem_ack = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Arbiter and sequencer that shares one unified single-port memory between the LC3 instruction-fetch path and the LC3 data-access path. It sits between the LC3 core memory interfaces and the memory model or SRAM. It serialises fetch and load/store requests and drives the core's `complete_instr` / `complete_data` handshakes.

## Interface
Parameters:
- `ADDR_W`, 16, address width of core and memory sides.
- `DATA_W`, 16, data width.
- `TIMEOUT_CYC`, 64, maximum wait cycles per memory access. Used only with `LC3_ARB_TIMEOUT_EN`. Must be ≥ 2.

Ports:
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instrmem_rd`  in  1  fetch request. Level signal, held until `complete_instr` is seen.
- `pc`  in  ADDR_W  fetch address.
- `Instr_dout`  out  DATA_W  fetched instruction.
- `complete_instr`  out  1  one-cycle fetch-done pulse.
- `data_req`  in  1  data request. Level signal, held until `complete_data` is seen.
- `Data_rd`  in  1  1 = read, 0 = write.
- `Data_addr`  in  ADDR_W  data address.
- `Data_din`  in  DATA_W  write data.
- `Data_dout`  out  DATA_W  read data.
- `complete_data`  out  1  one-cycle data-done pulse.
- `mem_req`  out  1  memory access active.
- `mem_we`  out  1  write strobe, qualified by `mem_req`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ack`.
- `mem_ack`  in  1  access complete. May be asserted in the first `mem_req` cycle.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
- States: `IDLE`, `BUS_I`, `BUS_D`, `DONE_I`, `DONE_D`.
- Arbitration in `IDLE`:
  - Only `data_req`: go to `BUS_D`.
  - Only `instrmem_rd`: go to `BUS_I`.
  - Both requests: data wins, unless the previous grant was data. In that case instruction wins.
  - `last_d` flag records the previous grant. It is updated on every grant.
  - No request: stay in `IDLE`.
- At the grant edge, capture address, write data and direction into registers. The memory-side outputs are driven from these registers only, so core-side changes during `BUS_*` have no effect.
- `BUS_I`:
  - `mem_req=1`, `mem_we=0`, `mem_addr` = captured `pc`.
  - On `mem_ack`: `Instr_dout <= mem_rdata`, go to `DONE_I`.
- `BUS_D`:
  - `mem_req=1`, `mem_we` = inverse of captured `Data_rd`.
  - On `mem_ack`: if read, `Data_dout <= mem_rdata`; go to `DONE_D`.
- `DONE_I` / `DONE_D`:
  - Assert `complete_instr` / `complete_data` (registered) for exactly one cycle.
  - `mem_req=0`.
  - Next state is always `IDLE`. A request is never re-granted in the cycle its completion pulse is high.
- A request dropped before completion does not abort the access. The access finishes and still pulses its complete.
- `Instr_dout` / `Data_dout` hold their value until the next successful read of the same type. Writes leave `Data_dout` unchanged.
- Reset (asynchronous, at any time, including mid-access):
  - State goes to `IDLE`; `last_d=0`.
  - All outputs go to 0, including `mem_req` immediately, `Instr_dout`, `Data_dout` and `timeout_err`.
  - An in-flight access is abandoned with no complete pulse.

## Timing
- Zero-wait memory (`mem_ack` in the first `BUS` cycle): request seen in `IDLE` at cycle 0, `BUS` in cycle 1, complete pulse in cycle 2, `IDLE` in cycle 3.
- With N wait cycles, the complete pulse comes in cycle 2+N.
- Maximum throughput is one access per 3 cycles.
- `mem_addr`, `mem_wdata` and `mem_we` are stable for the whole `BUS` period.
- `mem_rdata` is sampled only on the edge at which `mem_ack` is high in a `BUS` state. `mem_ack` in other states is ignored.
- `complete_*` and `*_dout` change together at the same edge.

## Configuration
- `LC3_ARB_TIMEOUT_EN` defined:
  - A wait counter clears on entry to `BUS_*` and increments each `BUS` cycle without `mem_ack`.
  - When it reaches `TIMEOUT_CYC`, the access is forced to `DONE_*`.
  - A forced read returns 0. For instructions, 0 is `BR` never, i.e. a NOP.
  - `timeout_err` is set and stays 1 until reset.
  - A `mem_ack` arriving on the same edge as the timeout wins: normal completion, no error.
- Not defined: no counter, `BUS_*` waits indefinitely for `mem_ack`, and `timeout_err` is tied to 0.

## Test plan
- Reset, then `instrmem_rd=1`, `pc=0x3000`, memory returns `0x1261` with zero wait.
  - Expect `mem_addr=0x3000` in cycle 1.
  - Expect `complete_instr=1` with `Instr_dout=0x1261` in cycle 2, then `IDLE`.
- Write `data_req=1`, `Data_rd=0`, `Data_addr=0x4000`, `Data_din=0xBEEF`, 3 wait cycles.
  - Expect `mem_we=1` held for 4 cycles.
  - Expect `complete_data` in cycle 5.
  - Expect `Data_dout` unchanged.
- Both requests asserted continuously from reset.
  - Grant order: D, I, D, I.
  - No two consecutive data grants while fetch is pending.
  - Each complete is a single-cycle pulse.
- `reset` asserted low during the second wait cycle of a `BUS_D` read.
  - `mem_req` falls the same cycle, no `complete_data`.
  - After release, a new fetch completes normally.
- With `LC3_ARB_TIMEOUT_EN` and `TIMEOUT_CYC=8`, a fetch with `mem_ack` never asserted.
  - Expect `complete_instr` after 8 `BUS` cycles with `Instr_dout=0x0000`.
  - Expect `timeout_err` to stay 1 through later successful accesses.
- Request dropped mid-access: `instrmem_rd` deasserted in the `BUS_I` cycle.
  - Access completes and `complete_instr` still pulses.
